// File: rtl/ingress_loader.sv
// Host-to-switch injection block: Avalon-MM writes fill three byte FIFOs,
// each drained independently onto a valid/ready switch input port.

module ingress_loader_port #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              push,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              ovf_set
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   stored;
    logic [ADDR_W:0]   stored_left;
    logic              pf_ok;
    logic              pf_next;
    logic              accept;
    logic              take;
    logic              issue;
    logic              push_ok;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign push_ok = push && !flush && !full;
    assign ovf_set = push && !flush && full;
    assign accept  = valid && ready;

    // count also covers the byte in FETCH or in the output register
    assign stored      = count - (ADDR_W+1)'(state != IDLE);
    assign take        = accept && enable && pf_ok;
    assign issue       = (state == IDLE) && enable && (stored != '0);
    assign stored_left = take ? stored - (ADDR_W+1)'(1) : stored;

    // Read the byte after the one being taken so back-to-back accepts see it in q
    assign rd_addr = take ? rd_ptr + ADDR_W'(1) : rd_ptr;
    assign pf_next = (state != IDLE) && (stored_left != '0);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
        q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            pf_ok  <= 1'b0;
            valid  <= 1'b0;
            data   <= '0;
        end else if (flush) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            pf_ok  <= 1'b0;
            valid  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (issue || take) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count <= count + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(accept);
            pf_ok <= pf_next;
            case (state)
                IDLE: begin
                    if (issue) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    data  <= q;
                    valid <= 1'b1;
                    state <= PRESENT;
                end
                PRESENT: begin
                    if (accept) begin
                        if (take) begin
                            data <= q;
                        end else begin
                            valid <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

module ingress_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [2:0]        address,
    input  logic [DATA_W-1:0] writedata,
    output logic [7:0]        readdata,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic              out_valid1,
    output logic              out_valid2,
    output logic              out_valid3,
    input  logic              out_ready1,
    input  logic              out_ready2,
    input  logic              out_ready3
);

    logic            wr_en;
    logic            rd_en;
    logic            ctrl_wr;
    logic            enable;
    logic [2:0]      ovf;
    logic [2:0]      ovf_set;
    logic [2:0]      full;
    logic [2:0]      empty;
    logic [ADDR_W:0] count1;
    logic [ADDR_W:0] count2;
    logic [ADDR_W:0] count3;

    assign wr_en   = chipselect && write;
    assign rd_en   = chipselect && read;
    assign ctrl_wr = wr_en && (address == 3'd3);

    function automatic logic [7:0] sat8(input logic [ADDR_W:0] c);
        if (32'(c) > 32'd255) begin
            return 8'hFF;
        end
        return 8'(c);
    endfunction

    ingress_loader_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port1 (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .push    (wr_en && (address == 3'd0)),
        .flush   (ctrl_wr && writedata[1]),
        .wdata   (writedata),
        .ready   (out_ready1),
        .data    (out_data1),
        .valid   (out_valid1),
        .count   (count1),
        .full    (full[0]),
        .empty   (empty[0]),
        .ovf_set (ovf_set[0])
    );

    ingress_loader_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port2 (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .push    (wr_en && (address == 3'd1)),
        .flush   (ctrl_wr && writedata[2]),
        .wdata   (writedata),
        .ready   (out_ready2),
        .data    (out_data2),
        .valid   (out_valid2),
        .count   (count2),
        .full    (full[1]),
        .empty   (empty[1]),
        .ovf_set (ovf_set[1])
    );

    ingress_loader_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port3 (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .push    (wr_en && (address == 3'd2)),
        .flush   (ctrl_wr && writedata[3]),
        .wdata   (writedata),
        .ready   (out_ready3),
        .data    (out_data3),
        .valid   (out_valid3),
        .count   (count3),
        .full    (full[2]),
        .empty   (empty[2]),
        .ovf_set (ovf_set[2])
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable <= 1'b0;
        end else if (ctrl_wr) begin
            enable <= writedata[0];
        end
    end

    // A drop coinciding with the clearing read re-arms its flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf <= '0;
        end else begin
            ovf <= ((rd_en && (address == 3'd4)) ? 3'b000 : ovf) | ovf_set;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (!rd_en) begin
            readdata <= 8'd251;
        end else begin
            case (address)
                3'd0:    readdata <= sat8(count1);
                3'd1:    readdata <= sat8(count2);
                3'd2:    readdata <= sat8(count3);
                3'd3:    readdata <= {1'b0, enable, empty[2], empty[1], empty[0],
                                      full[2], full[1], full[0]};
                3'd4:    readdata <= {5'b0, ovf};
                default: readdata <= 8'd252;
            endcase
        end
    end

endmodule

// File: tb/tb_ingress_loader.sv
// Bench for ingress_loader: register vector table, hand-built timing sequences
// and random traffic checked against per-port byte queues.

module tb_ingress_loader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cs, wr, rd;
    logic [2:0] addr;
    logic [7:0] wd;
    logic [7:0] readdata;
    logic [7:0] out_data1, out_data2, out_data3;
    logic       out_valid1, out_valid2, out_valid3;
    logic [2:0] rdy;

    always #5 clk = ~clk;

    ingress_loader #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (cs),
        .write      (wr),
        .read       (rd),
        .address    (addr),
        .writedata  (wd),
        .readdata   (readdata),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_data3  (out_data3),
        .out_valid1 (out_valid1),
        .out_valid2 (out_valid2),
        .out_valid3 (out_valid3),
        .out_ready1 (rdy[0]),
        .out_ready2 (rdy[1]),
        .out_ready3 (rdy[2])
    );

    logic [7:0] od [3];
    logic [2:0] ov;
    assign od[0] = out_data1;
    assign od[1] = out_data2;
    assign od[2] = out_data3;
    assign ov    = {out_valid3, out_valid2, out_valid1};

    // Reference model: bytes pushed and not yet accepted, per port
    logic [7:0] mq [3][$];
    bit         m_en;
    bit [2:0]   m_ovf;

    bit         pv [3];
    bit         pacc [3];
    bit         pfl [3];
    logic [7:0] pd [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         wr;
        bit         rd;
        logic [2:0] addr;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;
    vec_t vt [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        logic [7:0] exp_rd;
        bit         wr_en, rd_en, do_push;
        bit [2:0]   ovf_new;
        int         a, sz;
        wr_en   = cs && wr;
        rd_en   = cs && rd;
        a       = int'(addr);
        do_push = 0;
        ovf_new = '0;
        if (!rd_en) begin
            exp_rd = 8'd251;
        end else if (a <= 2) begin
            sz = mq[a].size();
            exp_rd = (sz > 255) ? 8'd255 : 8'(sz);
        end else if (a == 3) begin
            exp_rd = {1'b0, m_en, mq[2].size() == 0, mq[1].size() == 0, mq[0].size() == 0,
                      mq[2].size() >= 256, mq[1].size() >= 256, mq[0].size() >= 256};
        end else if (a == 4) begin
            exp_rd = {5'b0, m_ovf};
        end else begin
            exp_rd = 8'd252;
        end
        if (wr_en && a <= 2) begin
            if (mq[a].size() >= 256) ovf_new[a] = 1'b1;
            else do_push = 1;
        end
        for (int p = 0; p < 3; p++) begin
            pv[p]   = ov[p];
            pd[p]   = od[p];
            pacc[p] = ov[p] && rdy[p];
            pfl[p]  = wr_en && (a == 3) && wd[p+1];
            if (pacc[p]) begin
                if (mq[p].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out%0d_extra_byte: got 0x%0h, required no byte", p + 1, od[p]);
                end else begin
                    chk($sformatf("out%0d_data", p + 1), od[p], mq[p].pop_front());
                end
            end
        end
        if (do_push) mq[a].push_back(wd);
        for (int p = 0; p < 3; p++) if (pfl[p]) mq[p].delete();
        if (wr_en && a == 3) m_en = wd[0];
        m_ovf = ((rd_en && a == 4) ? 3'b000 : m_ovf) | ovf_new;

        @(posedge clk);
        #1;
        chk("readdata", readdata, exp_rd);
        for (int p = 0; p < 3; p++) begin
            if (pv[p] && !pacc[p] && !pfl[p]) begin
                chk($sformatf("out%0d_valid_held", p + 1), ov[p], 1);
                chk($sformatf("out%0d_data_stable", p + 1), od[p], pd[p]);
            end
        end
        cs = 0;
        wr = 0;
        rd = 0;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
        cs = 1; wr = 1; rd = 0; addr = a; wd = d;
        step();
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [7:0] v);
        cs = 1; wr = 0; rd = 1; addr = a;
        step();
        v = readdata;
    endtask

    task automatic do_reset();
        cs = 0; wr = 0; rd = 0;
        reset_n = 0;
        #2;
        chk("rst_valid", ov, 0);
        chk("rst_data1", od[0], 0);
        chk("rst_data2", od[1], 0);
        chk("rst_data3", od[2], 0);
        chk("rst_readdata", readdata, 0);
        for (int p = 0; p < 3; p++) begin
            mq[p].delete();
            pv[p] = 0;
        end
        m_en  = 0;
        m_ovf = '0;
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int p, input string nm);
        int n = 0;
        while (!ov[p] && n < 20) begin
            step();
            n++;
        end
        chk(nm, ov[p], 1);
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((mq[0].size() + mq[1].size() + mq[2].size() != 0 || ov != 0) && n < 3000) begin
            step();
            n++;
        end
        chk({nm, "_queued"}, mq[0].size() + mq[1].size() + mq[2].size(), 0);
        chk({nm, "_valid"}, ov, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  v;
        logic [23:0] vbits;
        int          op;

        vt[0] = '{0, 1, 3'd0, 8'h00, 8'h00};
        vt[1] = '{0, 1, 3'd3, 8'h00, 8'h38};
        vt[2] = '{0, 1, 3'd4, 8'h00, 8'h00};
        vt[3] = '{0, 1, 3'd5, 8'h00, 8'd252};
        vt[4] = '{0, 1, 3'd7, 8'h00, 8'd252};
        vt[5] = '{0, 0, 3'd0, 8'h00, 8'd251};
        vt[6] = '{1, 0, 3'd3, 8'h01, 8'd251};
        vt[7] = '{0, 1, 3'd3, 8'h00, 8'h78};
        vt[8] = '{1, 0, 3'd6, 8'h55, 8'd251};
        vt[9] = '{0, 1, 3'd3, 8'h00, 8'h78};

        cs = 0; wr = 0; rd = 0; addr = '0; wd = '0; rdy = '0;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            wr = vt[i].wr; rd = vt[i].rd; addr = vt[i].addr; wd = vt[i].wd;
            cs = vt[i].wr || vt[i].rd;
            step();
            chk($sformatf("vec%0d_readdata", i), readdata, vt[i].exp);
        end

        // single byte latency
        rdy = 3'b001;
        bus_wr(3'd0, 8'hA5);
        chk("lat_edge0", ov[0], 0);
        step();
        chk("lat_edge1", ov[0], 0);
        step();
        chk("lat_edge2_valid", ov[0], 1);
        chk("lat_edge2_data", od[0], 8'hA5);
        step();
        chk("lat_after_accept", ov[0], 0);
        bus_rd(3'd0, v);
        chk("lat_count0", v, 0);

        // ten-byte burst, no bubbles
        rdy = 3'b111;
        for (int i = 0; i < 24; i++) begin
            if (i < 10) bus_wr(3'd1, 8'(i));
            else step();
            vbits[i] = ov[1];
        end
        chk("burst_valid_mask", vbits, 24'h000FFC);

        // fill FIFO3 with drain disabled, then overflow
        bus_wr(3'd3, 8'h00);
        for (int i = 0; i < 256; i++) bus_wr(3'd2, 8'(i));
        bus_rd(3'd3, v);
        chk("full3_bit", v[2], 1);
        bus_rd(3'd2, v);
        chk("count3_saturated", v, 255);
        bus_wr(3'd2, 8'hFF);
        bus_rd(3'd4, v);
        chk("ovf_first_read", v, 8'h04);
        bus_rd(3'd4, v);
        chk("ovf_cleared", v, 8'h00);
        bus_wr(3'd3, 8'h01);
        wait_drain("fill_drain");

        // stall, then disable while presenting
        rdy = 3'b000;
        bus_wr(3'd0, 8'h11);
        bus_wr(3'd0, 8'h22);
        wait_valid(0, "stall_valid");
        repeat (5) step();
        chk("stall_data", od[0], 8'h11);
        bus_wr(3'd3, 8'h00);
        step();
        chk("disable_valid_held", ov[0], 1);
        rdy[0] = 1;
        step();
        rdy[0] = 0;
        repeat (6) step();
        chk("disable_no_fetch", ov[0], 0);
        bus_rd(3'd0, v);
        chk("disable_count0", v, 1);

        // flush during presentation
        bus_wr(3'd3, 8'h01);
        bus_wr(3'd1, 8'h31);
        bus_wr(3'd1, 8'h32);
        bus_wr(3'd1, 8'h33);
        wait_valid(1, "flush_pre_valid");
        bus_wr(3'd3, 8'h05);
        chk("flush_valid_drop", ov[1], 0);
        bus_rd(3'd1, v);
        chk("flush_count1", v, 0);
        bus_rd(3'd3, v);
        chk("flush_empty2", v[4], 1);
        repeat (4) step();
        chk("flush_stays_idle", ov[1], 0);

        // 300 bytes through FIFO1, pointer wrap
        rdy = 3'b111;
        for (int i = 0; i < 300; i++) bus_wr(3'd0, 8'(i));
        wait_drain("wrap_drain");
        bus_rd(3'd4, v);
        chk("wrap_no_ovf", v, 0);

        // reset with bytes queued
        rdy = 3'b000;
        for (int i = 0; i < 5; i++) bus_wr(3'd2, 8'(8'hC0 + i));
        wait_valid(2, "midreset_valid");
        do_reset();
        bus_rd(3'd2, v);
        chk("midreset_count3", v, 0);
        bus_wr(3'd3, 8'h01);
        rdy = 3'b111;
        repeat (4) step();
        chk("midreset_nothing_out", ov, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rdy = 3'($urandom_range(0, 7));
            op  = $urandom_range(0, 99);
            if (op < 45) begin
                cs = 1; wr = 1; addr = 3'($urandom_range(0, 2)); wd = 8'($urandom);
            end else if (op < 50) begin
                cs = 1; wr = 1; addr = 3'd3;
                wd = {4'b0, ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                      1'($urandom_range(0, 7) != 0)};
            end else if (op < 75) begin
                cs = 1; rd = 1; addr = 3'($urandom_range(0, 7));
            end else if (op < 80) begin
                cs = 0; wr = 1; addr = 3'($urandom_range(0, 7)); wd = 8'($urandom);
            end
            step();
        end
        bus_wr(3'd3, 8'h01);
        rdy = 3'b111;
        wait_drain("random_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
